// File: rtl/chan_prefix_eval_pipe.sv
// Per-channel source select and gate, then a run-time XOR/OR/AND prefix across channels.
// Two registered stages with valid/ready flow control and a saturating nonzero-result counter.
module chan_prefix_eval_pipe #(
  parameter int CH    = 4,
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        src_a,
  input  logic [W-1:0]        src_b,
  input  logic [W-1:0]        src_c,
  input  logic [W-1:0]        src_d,
  input  logic [2*CH-1:0]     sel,
  input  logic [CH-1:0]       en,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*W-1:0]     prefix,
  output logic [W-1:0]        total,
  output logic                nz_flag,
  output logic [CNT_W-1:0]    nz_count
);

  localparam logic [1:0] MODE_XOR = 2'd0;
  localparam logic [1:0] MODE_OR  = 2'd1;
  localparam logic [1:0] MODE_AND = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                s1_valid;
  logic [CH*W-1:0]     s1_terms;
  logic [1:0]          s1_mode;
  logic                s2_valid;

  logic [CH*W-1:0]     terms_next;
  logic [CH*W-1:0]     prefix_next;
  logic [W-1:0]        red_acc;

  logic                s1_load;
  logic                s2_load;
  logic                out_pop;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_pop   = s2_valid && out_ready;

  // Gated per-channel source mux, evaluated only for capture into stage 1.
  always_comb begin
    terms_next = '0;
    for (int i = 0; i < CH; i++) begin
      if (en[i]) begin
        case (sel[2*i +: 2])
          2'd0:    terms_next[W*i +: W] = src_a;
          2'd1:    terms_next[W*i +: W] = src_b;
          2'd2:    terms_next[W*i +: W] = src_c;
          default: terms_next[W*i +: W] = src_d;
        endcase
      end
    end
  end

  // Linear prefix chain over the captured terms; reserved mode falls back to XOR.
  always_comb begin
    prefix_next = '0;
    red_acc     = s1_terms[0 +: W];
    prefix_next[0 +: W] = red_acc;
    for (int i = 1; i < CH; i++) begin
      case (s1_mode)
        MODE_OR:  red_acc = red_acc | s1_terms[W*i +: W];
        MODE_AND: red_acc = red_acc & s1_terms[W*i +: W];
        default:  red_acc = red_acc ^ s1_terms[W*i +: W];
      endcase
      prefix_next[W*i +: W] = red_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_terms <= '0;
      s1_mode  <= MODE_XOR;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_terms <= terms_next;
        s1_mode  <= mode;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      prefix   <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        prefix   <= prefix_next;
      end else if (out_pop) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign total   = prefix[W*(CH-1) +: W];
  assign nz_flag = |total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_count <= '0;
    end else if (out_pop && nz_flag && (nz_count != CNT_MAX)) begin
      nz_count <= nz_count + CNT_W'(1);
    end
  end

endmodule
